sim_run_end_ctrl: RTL and testbench
===================================

# sim_run_end_ctrl

Parametrised end-of-run controller for the pipelined core's simulation and board test harness. It watches the core's halt condition and debounces it over a programmable delay. It then classifies the run as pass, breakpoint, exception or bad signature range, and on a clean looping halt streams the test signature out of RAM. Words are read through a word-read port and sent over a ready/valid stream, so a sim wrapper or a UART dumper can consume them.

## Interface
Parameters:
- HALT_DELAY, 4: cycles `halted_i` must stay high before classification; range 1 to 255.
- ADDR_WIDTH, 32: address width.
- RAM_BEGIN_ADDR, 32'h4000_0000: base subtracted from the signature addresses.
- MAX_SIG_WORDS, 4096: largest signature accepted, in words.

Ports:
- clk_i, input, 1: clock. One clock domain; all logic on the rising edge.
- rst_n_i, input, 1: reset. Asynchronous, active-low.
- halted_i, input, 1: core is in its halted state.
- looping_i, input, 1: the halt was caused by a looping instruction.
- mcause_i, input, 32: one-hot trap cause bits. Bit 3 is breakpoint.
- sig_begin_i, input, ADDR_WIDTH: absolute signature start address (inclusive).
- sig_end_i, input, ADDR_WIDTH: absolute signature end address (exclusive).
- mem_req_o, output, 1: word read request.
- mem_addr_o, output, ADDR_WIDTH: RAM-relative byte address of the read; always word-aligned.
- mem_ack_i, input, 1: read data is valid this cycle.
- mem_data_i, input, 32: read data.
- sig_valid_o, output, 1: a signature word is available.
- sig_data_o, output, 32: the signature word.
- sig_ready_i, input, 1: the consumer accepts the word.
- done_o, output, 1: classification and dump are complete. Sticky until reset.
- exit_code_o, output, 2: result code. 0 is pass, 1 is breakpoint, 2 is exception, 3 is bad range.
- mcause_o, output, 32: `mcause_i` latched at classification.
- word_count_o, output, 16: number of signature words accepted by the consumer.

## Operation
- States: IDLE, COUNT, CLASSIFY, READ, SEND, DONE.
- IDLE: when `halted_i` is high, load `cnt` with HALT_DELAY and go to COUNT.
- COUNT:
  - If `halted_i` is low, return to IDLE; nothing is latched.
  - Otherwise, if `cnt` is not 0, decrement it; if `cnt` is 0, go to CLASSIFY.
- CLASSIFY takes one cycle. It latches `mcause_o` and evaluates the conditions below in priority order:
  - `looping_i` is high and the range is valid: set `addr` to `sig_begin_i` minus RAM_BEGIN_ADDR, set `end` to `sig_end_i` minus RAM_BEGIN_ADDR, go to READ.
  - `looping_i` is high and the range is invalid: exit code 3, go to DONE.
  - `mcause_i[3]` is set: exit code 1, go to DONE.
  - Otherwise: exit code 2, go to DONE.
- Valid range requires all of the following:
  - `sig_begin_i` >= RAM_BEGIN_ADDR.
  - `sig_end_i` > `sig_begin_i`.
  - Both addresses have bits [1:0] equal to 0.
  - (end − begin)/4 <= MAX_SIG_WORDS.
- Arithmetic: all subtractions are unsigned at ADDR_WIDTH. The range comparisons use the unsubtracted absolute values.
- READ:
  - `mem_req_o` is 1 and `mem_addr_o` is `addr`; both are held until `mem_ack_i` is seen.
  - On ack, capture `mem_data_i` into `sig_data_o` and go to SEND.
- SEND:
  - `sig_valid_o` is 1; `sig_data_o` stays stable until `sig_ready_i` is seen.
  - On ready: `addr` += 4 and `word_count_o` += 1. If the new `addr` equals `end`, exit code 0 and go to DONE; otherwise go to READ.
- DONE: `done_o` is 1. The block stays here until reset; all inputs are ignored.
- Signals outside their states are ignored: `mem_ack_i` outside READ, `sig_ready_i` outside SEND, and `halted_i` after COUNT. A drop of `halted_i` mid-dump is ignored.

## Timing
- Reset values: every output is 0 and the state is IDLE. Assertion of `rst_n_i` clears everything immediately, asynchronously, including mid-dump.
- `halted_i` is first sampled high at edge k:
  - CLASSIFY is entered after edge k+HALT_DELAY+1.
  - For a non-dump result, `done_o` and `exit_code_o` are visible after edge k+HALT_DELAY+2.
- The first `mem_req_o` is visible the cycle after CLASSIFY.
- Each word costs at least 2 cycles: one in READ with a same-cycle ack, one in SEND with ready high.
- Pass `done_o` is visible the cycle after the last accepted word.
- `mem_req_o` and `sig_valid_o` are never high in the same cycle.

## Test plan
- Breakpoint: HALT_DELAY=4, `halted_i` rises at edge k and stays high, `mcause_i`=0x8, `looping_i`=0. Required: `done_o` high after edge k+6, `exit_code_o`=1, `mcause_o`=0x8, `mem_req_o` never asserted.
- Dump: `sig_begin_i`=0x4000_0100, `sig_end_i`=0x4000_0110, memory returns addr^0xA5A5_0000 with a zero-wait ack, `sig_ready_i`=1. Required:
  - Reads at 0x100, 0x104, 0x108 and 0x10C.
  - Words 0xA5A5_0100 through 0xA5A5_010C, in order.
  - `word_count_o`=4, `exit_code_o`=0.
- Backpressure: during the dump scenario, hold `sig_ready_i` low for 3 cycles on word 2. Required: `sig_data_o` stable and `sig_valid_o` high for those 3 cycles, no `mem_req_o`; the final result is the same as in the dump scenario.
- Glitch: `halted_i` high for 2 cycles, then low, with HALT_DELAY=4. Required: return to IDLE, `done_o`=0. A later sustained halt classifies normally.
- Bad range: `looping_i`=1 with `sig_end_i`=0x4000_0100 < `sig_begin_i`=0x4000_0200; repeat with begin=0x4000_0102. Required: `exit_code_o`=3, no reads.
- Reset: drive `rst_n_i` low between edges while in SEND on word 2. Required: all outputs 0 without waiting for an edge. After release, a new halt sequence runs from IDLE, with `word_count_o` restarting from 0.

Source files
------------

// File: rtl/sim_run_end_ctrl.sv
// End-of-run controller: debounces the core halt, classifies the run and,
// on a clean looping halt, streams the signature words out of RAM over a
// ready/valid interface.
module sim_run_end_ctrl #(
    parameter int unsigned                HALT_DELAY     = 4,
    parameter int unsigned                ADDR_WIDTH     = 32,
    parameter logic [ADDR_WIDTH-1:0]      RAM_BEGIN_ADDR = 'h4000_0000,
    parameter int unsigned                MAX_SIG_WORDS  = 4096
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic                  halted_i,
    input  logic                  looping_i,
    input  logic [31:0]           mcause_i,
    input  logic [ADDR_WIDTH-1:0] sig_begin_i,
    input  logic [ADDR_WIDTH-1:0] sig_end_i,
    output logic                  mem_req_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    input  logic                  mem_ack_i,
    input  logic [31:0]           mem_data_i,
    output logic                  sig_valid_o,
    output logic [31:0]           sig_data_o,
    input  logic                  sig_ready_i,
    output logic                  done_o,
    output logic [1:0]            exit_code_o,
    output logic [31:0]           mcause_o,
    output logic [15:0]           word_count_o
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_COUNT,
        ST_CLASSIFY,
        ST_READ,
        ST_SEND,
        ST_DONE
    } state_t;

    localparam logic [1:0] EXIT_PASS      = 2'd0;
    localparam logic [1:0] EXIT_BREAK     = 2'd1;
    localparam logic [1:0] EXIT_EXCEPTION = 2'd2;
    localparam logic [1:0] EXIT_BAD_RANGE = 2'd3;

    state_t                  r_state;
    state_t                  w_next;
    logic [7:0]              r_cnt;
    logic [ADDR_WIDTH-1:0]   r_addr;
    logic [ADDR_WIDTH-1:0]   r_end;
    logic [31:0]             r_sig_data;
    logic [1:0]              r_exit;
    logic [31:0]             r_mcause;
    logic [15:0]             r_word_count;

    logic [ADDR_WIDTH-1:0]   w_span;
    logic [ADDR_WIDTH-1:0]   w_span_words;
    logic                    w_range_ok;
    logic [ADDR_WIDTH-1:0]   w_addr_inc;
    logic                    w_last_word;

    // Range checks use the absolute addresses; only the word count uses the span.
    assign w_span       = sig_end_i - sig_begin_i;
    assign w_span_words = w_span >> 2;
    assign w_range_ok   = (sig_begin_i >= RAM_BEGIN_ADDR)
                        && (sig_end_i > sig_begin_i)
                        && (sig_begin_i[1:0] == 2'b00)
                        && (sig_end_i[1:0] == 2'b00)
                        && (w_span_words <= ADDR_WIDTH'(MAX_SIG_WORDS));

    assign w_addr_inc  = r_addr + ADDR_WIDTH'(4);
    assign w_last_word = (w_addr_inc == r_end);

    // State register
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) r_state <= ST_IDLE;
        else          r_state <= w_next;
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:     if (halted_i) w_next = ST_COUNT;
            ST_COUNT: begin
                if (!halted_i)        w_next = ST_IDLE;
                else if (r_cnt == '0) w_next = ST_CLASSIFY;
            end
            ST_CLASSIFY: w_next = (looping_i && w_range_ok) ? ST_READ : ST_DONE;
            ST_READ:     if (mem_ack_i) w_next = ST_SEND;
            ST_SEND:     if (sig_ready_i) w_next = w_last_word ? ST_DONE : ST_READ;
            ST_DONE:     w_next = ST_DONE;
            default:     w_next = ST_IDLE;
        endcase
    end

    // Datapath: debounce counter, classification results and dump pointers
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_cnt        <= '0;
            r_addr       <= '0;
            r_end        <= '0;
            r_sig_data   <= '0;
            r_exit       <= EXIT_PASS;
            r_mcause     <= '0;
            r_word_count <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (halted_i) r_cnt <= 8'(HALT_DELAY);
                end
                ST_COUNT: begin
                    if (halted_i && r_cnt != '0) r_cnt <= r_cnt - 8'd1;
                end
                ST_CLASSIFY: begin
                    r_mcause <= mcause_i;
                    if (looping_i && w_range_ok) begin
                        r_addr <= sig_begin_i - RAM_BEGIN_ADDR;
                        r_end  <= sig_end_i - RAM_BEGIN_ADDR;
                    end else if (looping_i) begin
                        r_exit <= EXIT_BAD_RANGE;
                    end else if (mcause_i[3]) begin
                        r_exit <= EXIT_BREAK;
                    end else begin
                        r_exit <= EXIT_EXCEPTION;
                    end
                end
                ST_READ: begin
                    if (mem_ack_i) r_sig_data <= mem_data_i;
                end
                ST_SEND: begin
                    if (sig_ready_i) begin
                        r_addr       <= w_addr_inc;
                        r_word_count <= r_word_count + 16'd1;
                        if (w_last_word) r_exit <= EXIT_PASS;
                    end
                end
                default: ;
            endcase
        end
    end

    assign mem_req_o    = (r_state == ST_READ);
    assign mem_addr_o   = r_addr;
    assign sig_valid_o  = (r_state == ST_SEND);
    assign sig_data_o   = r_sig_data;
    assign done_o       = (r_state == ST_DONE);
    assign exit_code_o  = r_exit;
    assign mcause_o     = r_mcause;
    assign word_count_o = r_word_count;

endmodule

// File: tb/tb_sim_run_end_ctrl.sv
// Self-checking bench for sim_run_end_ctrl with a zero-wait memory model
// and a scoreboard of expected read addresses and signature words.
module tb_sim_run_end_ctrl;

    logic        clk_i = 1'b0;
    logic        rst_n_i;
    logic        halted_i;
    logic        looping_i;
    logic [31:0] mcause_i;
    logic [31:0] sig_begin_i;
    logic [31:0] sig_end_i;
    logic        mem_req_o;
    logic [31:0] mem_addr_o;
    logic        mem_ack_i;
    logic [31:0] mem_data_i;
    logic        sig_valid_o;
    logic [31:0] sig_data_o;
    logic        sig_ready_i;
    logic        done_o;
    logic [1:0]  exit_code_o;
    logic [31:0] mcause_o;
    logic [15:0] word_count_o;

    int checks   = 0;
    int failures = 0;
    int reads_seen;
    int words_seen;
    logic [31:0] exp_addr_q[$];
    logic [31:0] exp_word_q[$];

    always #5 clk_i = ~clk_i;

    // Zero-wait memory: data is the relative address xor a fixed pattern
    assign mem_ack_i  = mem_req_o;
    assign mem_data_i = mem_addr_o ^ 32'hA5A5_0000;

    sim_run_end_ctrl #(
        .HALT_DELAY     (4),
        .ADDR_WIDTH     (32),
        .RAM_BEGIN_ADDR (32'h4000_0000),
        .MAX_SIG_WORDS  (4096)
    ) dut (
        .clk_i        (clk_i),
        .rst_n_i      (rst_n_i),
        .halted_i     (halted_i),
        .looping_i    (looping_i),
        .mcause_i     (mcause_i),
        .sig_begin_i  (sig_begin_i),
        .sig_end_i    (sig_end_i),
        .mem_req_o    (mem_req_o),
        .mem_addr_o   (mem_addr_o),
        .mem_ack_i    (mem_ack_i),
        .mem_data_i   (mem_data_i),
        .sig_valid_o  (sig_valid_o),
        .sig_data_o   (sig_data_o),
        .sig_ready_i  (sig_ready_i),
        .done_o       (done_o),
        .exit_code_o  (exit_code_o),
        .mcause_o     (mcause_o),
        .word_count_o (word_count_o)
    );

    // Scoreboard monitor: pops expected reads and words on each handshake
    always @(negedge clk_i) begin
        logic [31:0] e;
        if (rst_n_i) begin
            if (mem_req_o && sig_valid_o) begin
                checks++;
                failures++;
                $display("FAIL req_valid_overlap: mem_req_o=%b sig_valid_o=%b, required not both 1", mem_req_o, sig_valid_o);
            end
            if (mem_req_o && mem_ack_i) begin
                reads_seen++;
                checks++;
                if (exp_addr_q.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_read: addr %h, required no read", mem_addr_o);
                end else begin
                    e = exp_addr_q.pop_front();
                    if (mem_addr_o !== e) begin
                        failures++;
                        $display("FAIL read_addr: got %h required %h", mem_addr_o, e);
                    end
                end
            end
            if (sig_valid_o && sig_ready_i) begin
                words_seen++;
                checks++;
                if (exp_word_q.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_word: data %h, required no word", sig_data_o);
                end else begin
                    e = exp_word_q.pop_front();
                    if (sig_data_o !== e) begin
                        failures++;
                        $display("FAIL sig_word: got %h required %h", sig_data_o, e);
                    end
                end
            end
        end
    end

    task automatic do_reset();
        rst_n_i     = 1'b0;
        halted_i    = 1'b0;
        looping_i   = 1'b0;
        mcause_i    = '0;
        sig_begin_i = '0;
        sig_end_i   = '0;
        sig_ready_i = 1'b0;
        exp_addr_q.delete();
        exp_word_q.delete();
        reads_seen  = 0;
        words_seen  = 0;
        repeat (2) @(posedge clk_i);
        #1 rst_n_i = 1'b1;
    endtask

    task automatic push_dump(input logic [31:0] rel_begin, input int n);
        for (int i = 0; i < n; i++) begin
            exp_addr_q.push_back(rel_begin + 32'(4 * i));
            exp_word_q.push_back((rel_begin + 32'(4 * i)) ^ 32'hA5A5_0000);
        end
    endtask

    task automatic wait_done(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(posedge clk_i);
            #1;
            if (done_o) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({mem_req_o, mem_addr_o, sig_valid_o, sig_data_o, done_o, exit_code_o, mcause_o, word_count_o} !== '0) begin
            failures++;
            $display("FAIL reset_outputs: req=%b addr=%h valid=%b data=%h done=%b exit=%0d mcause=%h wc=%0d, required all 0",
                     mem_req_o, mem_addr_o, sig_valid_o, sig_data_o, done_o, exit_code_o, mcause_o, word_count_o);
        end
    endtask

    task automatic test_breakpoint();
        do_reset();
        mcause_i  = 32'h8;
        looping_i = 1'b0;
        halted_i  = 1'b1;           // first sampled at edge k
        for (int i = 0; i <= 5; i++) begin
            @(posedge clk_i);
            #1;
            checks++;
            if (done_o !== 1'b0 || mem_req_o !== 1'b0) begin
                failures++;
                $display("FAIL bp_early: edge k+%0d done=%b req=%b, required 0 0", i, done_o, mem_req_o);
            end
        end
        @(posedge clk_i);
        #1;
        checks++;
        if (done_o !== 1'b1) begin
            failures++;
            $display("FAIL bp_done_timing: done=%b after edge k+6, required 1", done_o);
        end
        checks++;
        if (exit_code_o !== 2'd1) begin
            failures++;
            $display("FAIL bp_exit: got %0d required 1", exit_code_o);
        end
        checks++;
        if (mcause_o !== 32'h8) begin
            failures++;
            $display("FAIL bp_mcause: got %h required 00000008", mcause_o);
        end
        checks++;
        if (reads_seen != 0) begin
            failures++;
            $display("FAIL bp_no_reads: got %0d reads required 0", reads_seen);
        end
    endtask

    task automatic test_dump();
        do_reset();
        push_dump(32'h100, 4);
        sig_begin_i = 32'h4000_0100;
        sig_end_i   = 32'h4000_0110;
        looping_i   = 1'b1;
        sig_ready_i = 1'b1;
        halted_i    = 1'b1;
        for (int i = 0; i <= 5; i++) begin
            @(posedge clk_i);
            #1;
        end
        @(posedge clk_i);
        #1;
        checks++;
        if (mem_req_o !== 1'b1 || mem_addr_o !== 32'h100) begin
            failures++;
            $display("FAIL dump_first_req: req=%b addr=%h after edge k+6, required 1 00000100", mem_req_o, mem_addr_o);
        end
        halted_i = 1'b0;            // ignored mid-dump
        repeat (7) @(posedge clk_i);
        #1;
        checks++;
        if (done_o !== 1'b0) begin
            failures++;
            $display("FAIL dump_done_early: done=%b after edge k+13, required 0", done_o);
        end
        @(posedge clk_i);
        #1;
        checks++;
        if (done_o !== 1'b1) begin
            failures++;
            $display("FAIL dump_done_timing: done=%b after edge k+14, required 1", done_o);
        end
        checks++;
        if (word_count_o !== 16'd4 || exit_code_o !== 2'd0) begin
            failures++;
            $display("FAIL dump_result: wc=%0d exit=%0d, required 4 0", word_count_o, exit_code_o);
        end
        checks++;
        if (exp_addr_q.size() != 0 || exp_word_q.size() != 0 || reads_seen != 4 || words_seen != 4) begin
            failures++;
            $display("FAIL dump_scoreboard: reads=%0d words=%0d left=%0d/%0d, required 4 4 0/0",
                     reads_seen, words_seen, exp_addr_q.size(), exp_word_q.size());
        end
    endtask

    task automatic test_backpressure();
        int  low_cycles;
        bit  finished;
        low_cycles = 0;
        finished   = 1'b0;
        do_reset();
        push_dump(32'h100, 4);
        sig_begin_i = 32'h4000_0100;
        sig_end_i   = 32'h4000_0110;
        looping_i   = 1'b1;
        sig_ready_i = 1'b1;
        halted_i    = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk_i);
            #1;
            if (done_o) begin
                finished = 1'b1;
                break;
            end
            if (sig_valid_o && word_count_o == 16'd1 && low_cycles < 3) begin
                sig_ready_i = 1'b0;
                low_cycles++;
                checks++;
                if (sig_valid_o !== 1'b1 || sig_data_o !== 32'hA5A5_0104 || mem_req_o !== 1'b0) begin
                    failures++;
                    $display("FAIL bp_hold: valid=%b data=%h req=%b, required 1 a5a50104 0", sig_valid_o, sig_data_o, mem_req_o);
                end
            end else begin
                sig_ready_i = 1'b1;
            end
        end
        checks++;
        if (!finished || low_cycles != 3) begin
            failures++;
            $display("FAIL backpressure_timeout: done=%b low_cycles=%0d, required 1 3", finished, low_cycles);
        end
        checks++;
        if (word_count_o !== 16'd4 || exit_code_o !== 2'd0 || words_seen != 4 || exp_word_q.size() != 0) begin
            failures++;
            $display("FAIL backpressure_result: wc=%0d exit=%0d words=%0d, required 4 0 4", word_count_o, exit_code_o, words_seen);
        end
    endtask

    task automatic test_glitch();
        bit ok;
        do_reset();
        mcause_i  = 32'h4;
        looping_i = 1'b0;
        halted_i  = 1'b1;
        repeat (2) @(posedge clk_i);
        #1 halted_i = 1'b0;
        repeat (10) @(posedge clk_i);
        #1;
        checks++;
        if (done_o !== 1'b0 || mcause_o !== 32'h0) begin
            failures++;
            $display("FAIL glitch_ignored: done=%b mcause=%h, required 0 00000000", done_o, mcause_o);
        end
        halted_i = 1'b1;
        wait_done(20, ok);
        checks++;
        if (!ok || exit_code_o !== 2'd2 || mcause_o !== 32'h4) begin
            failures++;
            $display("FAIL glitch_then_halt: done=%b exit=%0d mcause=%h, required 1 2 00000004", ok, exit_code_o, mcause_o);
        end
    endtask

    task automatic test_bad_range();
        logic [31:0] begins[4] = '{32'h4000_0200, 32'h4000_0102, 32'h3FFF_FFF0, 32'h4000_0000};
        logic [31:0] ends[4]   = '{32'h4000_0100, 32'h4000_0110, 32'h4000_0010, 32'h4000_4004};
        bit ok;
        for (int i = 0; i < 4; i++) begin
            do_reset();
            sig_begin_i = begins[i];
            sig_end_i   = ends[i];
            looping_i   = 1'b1;
            sig_ready_i = 1'b1;
            halted_i    = 1'b1;
            wait_done(20, ok);
            checks++;
            if (!ok || exit_code_o !== 2'd3 || reads_seen != 0) begin
                failures++;
                $display("FAIL bad_range_%0d: done=%b exit=%0d reads=%0d, required 1 3 0", i, ok, exit_code_o, reads_seen);
            end
        end
    endtask

    task automatic test_reset_mid_dump();
        bit ok;
        bit in_send;
        in_send = 1'b0;
        do_reset();
        push_dump(32'h100, 4);
        mcause_i    = 32'h10;
        sig_begin_i = 32'h4000_0100;
        sig_end_i   = 32'h4000_0110;
        looping_i   = 1'b1;
        sig_ready_i = 1'b1;
        halted_i    = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(posedge clk_i);
            #1;
            if (sig_valid_o && word_count_o == 16'd1) begin
                sig_ready_i = 1'b0;
                in_send = 1'b1;
                break;
            end
        end
        checks++;
        if (!in_send) begin
            failures++;
            $display("FAIL reset_reach_send: in_send=%b, required 1", in_send);
        end
        #2 rst_n_i = 1'b0;
        #1;
        checks++;
        if ({mem_req_o, mem_addr_o, sig_valid_o, sig_data_o, done_o, exit_code_o, mcause_o, word_count_o} !== '0) begin
            failures++;
            $display("FAIL async_reset: req=%b addr=%h valid=%b data=%h done=%b exit=%0d mcause=%h wc=%0d, required all 0",
                     mem_req_o, mem_addr_o, sig_valid_o, sig_data_o, done_o, exit_code_o, mcause_o, word_count_o);
        end
        do_reset();
        checks++;
        if (word_count_o !== 16'd0) begin
            failures++;
            $display("FAIL reset_wc: got %0d required 0", word_count_o);
        end
        push_dump(32'h100, 4);
        sig_begin_i = 32'h4000_0100;
        sig_end_i   = 32'h4000_0110;
        looping_i   = 1'b1;
        sig_ready_i = 1'b1;
        halted_i    = 1'b1;
        wait_done(50, ok);
        checks++;
        if (!ok || word_count_o !== 16'd4 || exit_code_o !== 2'd0 || words_seen != 4) begin
            failures++;
            $display("FAIL rerun_after_reset: done=%b wc=%0d exit=%0d words=%0d, required 1 4 0 4", ok, word_count_o, exit_code_o, words_seen);
        end
    endtask

    initial begin
        test_reset();
        test_breakpoint();
        test_dump();
        test_backpressure();
        test_glitch();
        test_bad_range();
        test_reset_mid_dump();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
